eq2_cmp: RTL and testbench

//  Registered W-bit equality comparator built from per-bit XNOR "eq cells". Each cell exposes
//  the two sum-of-products terms: s1 = both bits 0, s2 = both bits 1.

---
 rtl/eq2_pkg.sv | 10 +
 rtl/eq1_cell.sv | 16 +
 rtl/eq2_cmp.sv | 106 ++++++++++
 tb/tb_eq2_cmp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/eq2_pkg.sv
// Shared definitions for the registered equality comparator: default widths
// and the counter type used at the default counter width.
package eq2_pkg;

    localparam int W_DEF     = 1;
    localparam int CNT_W_DEF = 16;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage : eq2_pkg

// File: rtl/eq1_cell.sv
// One-bit equality cell. Exposes both product terms of the XNOR so the top
// level can report "both zero" and "both one" alongside plain equality.
module eq1_cell (
    input  logic a,
    input  logic b,
    output logic e1,
    output logic e2,
    output logic eq
);

    // Product terms: e1 = both bits low, e2 = both bits high.
    assign e1 = ~a & ~b;
    assign e2 =  a &  b;
    assign eq =  e1 | e2;

endmodule : eq1_cell

// File: rtl/eq2_cmp.sv
// Registered W-bit equality comparator with debug visibility of the
// aggregated product terms and a saturating count of mismatching samples.
// All outputs come straight from flops; results appear one cycle after a
// valid sample.
module eq2_cmp
    import eq2_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             clr_cnt,
    output logic             out_valid,
    output logic             s,
    output logic             s1,
    output logic             s2,
    output logic [CNT_W-1:0] mism_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0]     e1_s;
    logic [W-1:0]     e2_s;
    logic [W-1:0]     eq_s;
    logic             s_next_s;
    logic             s1_next_s;
    logic             s2_next_s;
    logic             cnt_inc_s;

    logic             out_valid_r;
    logic             s_r;
    logic             s1_r;
    logic             s2_r;
    logic [CNT_W-1:0] cnt_r;

    // One eq cell per operand bit.
    for (genvar i = 0; i < W; i++) begin : g_cell
        eq1_cell u_cell (
            .a  (x[i]),
            .b  (y[i]),
            .e1 (e1_s[i]),
            .e2 (e2_s[i]),
            .eq (eq_s[i])
        );
    end

    assign s_next_s  = &eq_s;
    assign s1_next_s = &e1_s;
    assign s2_next_s = &e2_s;

    // Decide whether this cycle's sample bumps the mismatch counter.
    always_comb begin
        cnt_inc_s = 1'b0;
        if (in_valid && !s_next_s && (cnt_r != CNT_MAX)) begin
            cnt_inc_s = 1'b1;
        end else begin
            cnt_inc_s = 1'b0;
        end
    end

    // Result registers: capture reductions on a valid sample, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            s_r         <= 1'b0;
            s1_r        <= 1'b0;
            s2_r        <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                s_r  <= s_next_s;
                s1_r <= s1_next_s;
                s2_r <= s2_next_s;
            end else begin
                s_r  <= s_r;
                s1_r <= s1_r;
                s2_r <= s2_r;
            end
        end
    end

    // Saturating mismatch counter; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr_cnt) begin
            cnt_r <= '0;
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign s1        = s1_r;
    assign s2        = s2_r;
    assign mism_cnt  = cnt_r;

endmodule : eq2_cmp

// File: tb/tb_eq2_cmp.sv
// Bench for eq2_cmp: one 1-bit instance with the default 16-bit counter and
// one 8-bit instance with a 2-bit counter, checked against a behavioural model.
module tb_eq2_cmp;

    logic        clk;
    logic        rst_n;

    logic        a_iv, a_clr, a_x, a_y;
    logic        a_ov, a_s, a_s1, a_s2;
    logic [15:0] a_cnt;

    logic        b_iv, b_clr;
    logic [7:0]  b_x, b_y;
    logic        b_ov, b_s, b_s1, b_s2;
    logic [1:0]  b_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    int ma_ov, ma_s, ma_s1, ma_s2, ma_cnt;
    int mb_ov, mb_s, mb_s1, mb_s2, mb_cnt;

    typedef struct {
        logic x;
        logic y;
        int   s;
        int   s1;
        int   s2;
        int   cnt;
    } vec_t;

    vec_t tbl [4];

    eq2_cmp #(.W(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .x(a_x), .y(a_y),
        .clr_cnt(a_clr), .out_valid(a_ov), .s(a_s), .s1(a_s1), .s2(a_s2),
        .mism_cnt(a_cnt)
    );

    eq2_cmp #(.W(8), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .x(b_x), .y(b_y),
        .clr_cnt(b_clr), .out_valid(b_ov), .s(b_s), .s1(b_s1), .s2(b_s2),
        .mism_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic chk_all();
        chk("a_out_valid", int'(a_ov), ma_ov);
        chk("a_s",         int'(a_s),  ma_s);
        chk("a_s1",        int'(a_s1), ma_s1);
        chk("a_s2",        int'(a_s2), ma_s2);
        chk("a_mism_cnt",  int'(a_cnt), ma_cnt);
        chk("b_out_valid", int'(b_ov), mb_ov);
        chk("b_s",         int'(b_s),  mb_s);
        chk("b_s1",        int'(b_s1), mb_s1);
        chk("b_s2",        int'(b_s2), mb_s2);
        chk("b_mism_cnt",  int'(b_cnt), mb_cnt);
    endtask

    task automatic model_reset();
        ma_ov = 0; ma_s = 0; ma_s1 = 0; ma_s2 = 0; ma_cnt = 0;
        mb_ov = 0; mb_s = 0; mb_s1 = 0; mb_s2 = 0; mb_cnt = 0;
    endtask

    // Advance one clock: update the model from the stable inputs, then compare.
    task automatic tick();
        @(posedge clk);
        if (a_iv) begin
            ma_ov = 1;
            ma_s  = (a_x == a_y) ? 1 : 0;
            ma_s1 = (a_x == 1'b0 && a_y == 1'b0) ? 1 : 0;
            ma_s2 = (a_x == 1'b1 && a_y == 1'b1) ? 1 : 0;
        end else begin
            ma_ov = 0;
        end
        if (a_clr) ma_cnt = 0;
        else if (a_iv && a_x != a_y && ma_cnt < 65535) ma_cnt++;

        if (b_iv) begin
            mb_ov = 1;
            mb_s  = (b_x == b_y) ? 1 : 0;
            mb_s1 = (b_x == 8'h00 && b_y == 8'h00) ? 1 : 0;
            mb_s2 = (b_x == 8'hFF && b_y == 8'hFF) ? 1 : 0;
        end else begin
            mb_ov = 0;
        end
        if (b_clr) mb_cnt = 0;
        else if (b_iv && b_x != b_y && mb_cnt < 3) mb_cnt++;
        #1;
        chk_all();
    endtask

    initial begin
        tbl[0] = '{x: 1'b0, y: 1'b0, s: 1, s1: 1, s2: 0, cnt: 0};
        tbl[1] = '{x: 1'b1, y: 1'b0, s: 0, s1: 0, s2: 0, cnt: 1};
        tbl[2] = '{x: 1'b1, y: 1'b1, s: 1, s1: 0, s2: 1, cnt: 1};
        tbl[3] = '{x: 1'b0, y: 1'b1, s: 0, s1: 0, s2: 0, cnt: 2};

        rst_n = 1'b0;
        a_iv = 1'b0; a_clr = 1'b0; a_x = 1'b0; a_y = 1'b0;
        b_iv = 1'b0; b_clr = 1'b0; b_x = 8'h00; b_y = 8'h00;
        model_reset();
        #12;
        chk_all();
        rst_n = 1'b1;
        tick();
        tick();

        // W=1 basic truth table, one sample per cycle.
        for (int i = 0; i < 4; i++) begin
            a_iv = 1'b1; a_x = tbl[i].x; a_y = tbl[i].y;
            tick();
            chk("tbl_s",   int'(a_s),   tbl[i].s);
            chk("tbl_s1",  int'(a_s1),  tbl[i].s1);
            chk("tbl_s2",  int'(a_s2),  tbl[i].s2);
            chk("tbl_cnt", int'(a_cnt), tbl[i].cnt);
            chk("tbl_ov",  int'(a_ov),  1);
        end

        // Idle cycle: out_valid drops, result bits hold.
        a_iv = 1'b0; a_x = 1'b1; a_y = 1'b1;
        tick();
        chk("hold_ov", int'(a_ov), 0);
        chk("hold_s",  int'(a_s),  0);

        // W=8, CNT_W=2: saturation then clear beating a mismatch.
        for (int i = 0; i < 4; i++) begin
            b_iv = 1'b1; b_x = 8'hA5; b_y = 8'h5A;
            tick();
        end
        chk("sat_cnt", int'(b_cnt), 3);
        b_clr = 1'b1;
        tick();
        chk("clr_cnt", int'(b_cnt), 0);
        b_clr = 1'b0;
        b_x = 8'hFF; b_y = 8'hFF;
        tick();
        chk("b_ones_s2", int'(b_s2), 1);
        b_x = 8'h00; b_y = 8'h00;
        tick();
        chk("b_zero_s1", int'(b_s1), 1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 300; n++) begin
            a_iv  = 1'($urandom_range(0, 3) != 0);
            a_x   = 1'($urandom);
            a_y   = 1'($urandom);
            a_clr = 1'($urandom_range(0, 15) == 0);
            b_iv  = 1'($urandom_range(0, 3) != 0);
            b_clr = 1'($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0: begin b_x = 8'($urandom); b_y = 8'($urandom); end
                1: begin b_x = 8'($urandom); b_y = b_x; end
                2: begin b_x = 8'h00; b_y = 8'h00; end
                default: begin b_x = 8'hFF; b_y = 8'hFF; end
            endcase
            tick();
        end
        a_clr = 1'b0; b_clr = 1'b0;

        // Asynchronous reset mid-cycle while a result is valid.
        a_iv = 1'b1; a_x = 1'b1; a_y = 1'b1;
        b_iv = 1'b1; b_x = 8'hFF; b_y = 8'hFF;
        tick();
        chk("pre_rst_ov", int'(a_ov), 1);
        a_x = 1'b1; a_y = 1'b0;
        b_x = 8'h12; b_y = 8'h34;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all();
        a_iv = 1'b0; b_iv = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_s2", int'(b_s2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_eq2_cmp
